// File: rtl/stopwatch_cnt_if.sv
// Control levels in, display word and tick out, between the mode controller and the stopwatch counter.
interface stopwatch_cnt_if;
    logic        run_md;
    logic        disp_md;
    logic        clr_on;
    logic [15:0] bcd;
    logic        tick;
    logic        dp_pos;

    modport master (output run_md, disp_md, clr_on, input bcd, tick, dp_pos);
    modport slave  (input run_md, disp_md, clr_on, output bcd, tick, dp_pos);
endinterface

// File: rtl/stopwatch_cnt.sv
// Stopwatch: centisecond prescaler feeding a BCD mm:ss.cc chain with a registered display mux.
// Define STOPWATCH_WRAP_EN to roll over at 59:59.99; otherwise the count saturates there.
module stopwatch_cnt #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic           clk,
    input  logic           rst,
    stopwatch_cnt_if.slave sw
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_TOP = PW'(DIV - 1);

    generate
        if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
            $error("stopwatch_cnt: CLK_HZ/TICK_HZ must be an integer >= 2");
        end
    endgenerate

    // Returns {carry, next}; carry is set when the pair rolls from {hi_max,9} to 00.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [3:0] hi_max);
        logic [8:0] r;
        if (v == {hi_max, 4'd9})
            r = {1'b1, 8'h00};
        else if (v[3:0] == 4'd9)
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    cs_q, cs_d, sec_q, sec_d, min_q, min_d;
    logic [15:0]   bcd_q, bcd_d;
    logic          tick_q, tick_d;
    logic          dp_pos_q, dp_pos_d;

    logic [8:0]    cs_nx, sec_nx, min_nx;
    logic          clr, at_max, hold_max;

    assign clr    = sw.clr_on & ~sw.run_md;
    assign cs_nx  = bcd_inc(cs_q, 4'd9);
    assign sec_nx = bcd_inc(sec_q, 4'd5);
    assign min_nx = bcd_inc(min_q, 4'd5);
    // All three pairs at their top value is exactly 59:59.99.
    assign at_max = cs_nx[8] & sec_nx[8] & min_nx[8];

`ifdef STOPWATCH_WRAP_EN
    assign hold_max = 1'b0;
`else
    assign hold_max = at_max;
`endif

    always_comb begin
        pre_d    = pre_q;
        cs_d     = cs_q;
        sec_d    = sec_q;
        min_d    = min_q;
        tick_d   = 1'b0;
        bcd_d    = sw.disp_md ? {min_q, sec_q} : {sec_q, cs_q};
        dp_pos_d = sw.disp_md;

        if (clr) begin
            pre_d = '0;
            cs_d  = 8'h00;
            sec_d = 8'h00;
            min_d = 8'h00;
        end else if (sw.run_md) begin
            if (hold_max) begin
                // Saturated: park the prescaler so no further ticks are produced.
                pre_d = '0;
            end else if (pre_q == PRE_TOP) begin
                pre_d  = '0;
                tick_d = 1'b1;
                cs_d   = cs_nx[7:0];
                if (cs_nx[8]) begin
                    sec_d = sec_nx[7:0];
                    if (sec_nx[8])
                        min_d = min_nx[7:0];
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q    <= '0;
            cs_q     <= 8'h00;
            sec_q    <= 8'h00;
            min_q    <= 8'h00;
            bcd_q    <= 16'h0000;
            tick_q   <= 1'b0;
            dp_pos_q <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            cs_q     <= cs_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            bcd_q    <= bcd_d;
            tick_q   <= tick_d;
            dp_pos_q <= dp_pos_d;
        end
    end

    assign sw.bcd    = bcd_q;
    assign sw.tick   = tick_q;
    assign sw.dp_pos = dp_pos_q;
endmodule

// File: tb/tb_stopwatch_cnt.sv
// Bench for stopwatch_cnt at DIV=10: tick-indexed scoreboard plus directed control checks.
module tb_stopwatch_cnt;
    logic clk;
    logic rst;

    stopwatch_cnt_if sw ();

    stopwatch_cnt #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw)
    );

    typedef struct {
        int          idx;
        logic [15:0] bcd;
    } sb_ent_t;

    sb_ent_t sb[$];
    int checks   = 0;
    int errors   = 0;
    int tick_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input logic [15:0] v);
        sb_ent_t e;
        e.idx = idx;
        e.bcd = v;
        sb.push_back(e);
    endtask

    // Running cycles until tick is seen (bounded at 40).
    task automatic wait_tick(output int n);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (sw.tick) break;
        end
    endtask

    // Monitor: counts ticks; for a scoreboarded tick, compares bcd one edge later.
    initial begin : monitor
        logic        pend;
        logic [15:0] pend_exp;
        pend     = 1'b0;
        pend_exp = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (pend) begin
                chk("sb_bcd", {16'h0, sw.bcd}, {16'h0, pend_exp});
                pend = 1'b0;
            end
            if (sw.tick) begin
                tick_cnt++;
                if (sb.size() > 0 && sb[0].idx == tick_cnt) begin
                    pend_exp = sb[0].bcd;
                    pend     = 1'b1;
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int base;
        int seen;
        sw.run_md  = 1'b0;
        sw.disp_md = 1'b0;
        sw.clr_on  = 1'b0;
        rst        = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bcd", {16'h0, sw.bcd}, 0);
        chk("rst_tick", {31'h0, sw.tick}, 0);
        chk("rst_dp", {31'h0, sw.dp_pos}, 0);

        // Reset mid-count
        rst       = 1'b1;
        sw.run_md = 1'b1;
        repeat (20) @(negedge clk);
        chk("run20_bcd", {16'h0, sw.bcd}, 32'h0001);
        chk("run20_tick", {31'h0, sw.tick}, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_bcd", {16'h0, sw.bcd}, 0);
        chk("async_rst_tick", {31'h0, sw.tick}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_tick(n);
        chk("rst_first_tick", n, 10);

        // Clear a partial prescale while paused
        repeat (3) @(negedge clk);
        sw.run_md = 1'b0;
        sw.clr_on = 1'b1;
        @(negedge clk);
        sw.clr_on = 1'b0;
        @(negedge clk);
        chk("clr_bcd", {16'h0, sw.bcd}, 0);

        // Carry chain over one minute
        base = tick_cnt;
        push(base + 1, 16'h0001);
        push(base + 37, 16'h0037);
        push(base + 100, 16'h0100);
        push(base + 5999, 16'h0059);
        push(base + 6000, 16'h0100);
        sw.run_md = 1'b1;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            if (i == 9)  chk("clr_pre_t9", {31'h0, sw.tick}, 0);
            if (i == 10) chk("clr_pre_t10", {31'h0, sw.tick}, 1);
        end
        chk("carry_100_ticks", tick_cnt - base, 100);
        @(negedge clk);
        sw.disp_md = 1'b1;
        repeat (58999) @(negedge clk);
        chk("carry_6000_ticks", tick_cnt - base, 6000);
        chk("carry_dp", {31'h0, sw.dp_pos}, 1);

        // Pause keeps the partial centisecond
        sw.run_md = 1'b0;
        sw.clr_on = 1'b1;
        @(negedge clk);
        sw.clr_on  = 1'b0;
        sw.disp_md = 1'b0;
        @(negedge clk);
        base = tick_cnt;
        push(base + 2, 16'h0002);
        sw.run_md = 1'b1;
        repeat (15) @(negedge clk);
        sw.run_md = 1'b0;
        repeat (50) @(negedge clk);
        chk("pause_bcd", {16'h0, sw.bcd}, 32'h0001);
        chk("pause_ticks", tick_cnt - base, 1);
        sw.run_md = 1'b1;
        wait_tick(n);
        chk("resume_tick", n, 5);

        // Clear while running is ignored
        sw.clr_on = 1'b1;
        repeat (12) @(negedge clk);
        chk("clr_ignored", {16'h0, sw.bcd}, 32'h0003);
        sw.clr_on = 1'b0;
        repeat (7) @(negedge clk);
        // Prescaler now sits at its terminal value: clear must win
        sw.run_md = 1'b0;
        sw.clr_on = 1'b1;
        @(negedge clk);
        sw.clr_on = 1'b0;
        @(negedge clk);
        chk("clr_tc_bcd", {16'h0, sw.bcd}, 0);
        sw.run_md = 1'b1;
        wait_tick(n);
        chk("clr_tc_pre", n, 10);

        // Display switch at 12:34.56
        sw.run_md = 1'b0;
        force dut.cs_q  = 8'h56;
        force dut.sec_q = 8'h34;
        force dut.min_q = 8'h12;
        @(negedge clk);
        release dut.cs_q;
        release dut.sec_q;
        release dut.min_q;
        @(negedge clk);
        chk("disp_sscc", {16'h0, sw.bcd}, 32'h3456);
        chk("disp_dp0", {31'h0, sw.dp_pos}, 0);
        sw.disp_md = 1'b1;
        @(negedge clk);
        chk("disp_mmss", {16'h0, sw.bcd}, 32'h1234);
        chk("disp_dp1", {31'h0, sw.dp_pos}, 1);
        sw.run_md = 1'b1;
        repeat (10) @(negedge clk);
        sw.run_md  = 1'b0;
        sw.disp_md = 1'b0;
        @(negedge clk);
        chk("disp_undisturbed", {16'h0, sw.bcd}, 32'h3457);

        // Limit at 59:59.99
        force dut.cs_q  = 8'h99;
        force dut.sec_q = 8'h59;
        force dut.min_q = 8'h59;
        sw.disp_md = 1'b1;
        @(negedge clk);
        release dut.cs_q;
        release dut.sec_q;
        release dut.min_q;
        @(negedge clk);
        chk("lim_start", {16'h0, sw.bcd}, 32'h5959);
        sw.run_md = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen += int'(sw.tick);
        end
        sw.run_md = 1'b0;
        @(negedge clk);
`ifdef STOPWATCH_WRAP_EN
        chk("lim_wrap_tick", seen, 1);
        chk("lim_wrap_bcd", {16'h0, sw.bcd}, 32'h0000);
`else
        chk("lim_sat_tick", seen, 0);
        chk("lim_sat_bcd", {16'h0, sw.bcd}, 32'h5959);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
